signal_extension_pipe: RTL and testbench
========================================

// Module: signal_extension_pipe
// PURPOSE
//  Parametrised, pipelined successor of the combinational signal extender.
//  Widens an IN_W-bit immediate to OUT_W bits in one of four modes: zero-, sign-,
//  sign-shift-left-1 or upper-load. Input and output use valid/ready handshakes.
//  A 2-entry skid buffer gives a registered In_Ready and full throughput.
//  Sits between instruction decode and the ALU operand mux of the datapath.
// PARAMETERS
//  IN_W     11  width of Input; 1..OUT_W
//  OUT_W    16  width of Output; IN_W..32
//  CNT_W    16  width of Xfer_Count (only with SIGNAL_EXT_PIPE_COUNT_EN)
// PORTS
//  Clock       in   1      rising-edge clock
//  Reset       in   1      synchronous, active-low reset
//  Input       in   IN_W   immediate to extend
//  Mode        in   2      00 zero, 01 sign, 10 sign<<1, 11 upper-load
//  In_Valid    in   1      Input/Mode valid
//  In_Ready    out  1      block accepts Input this cycle (registered)
//  Output      out  OUT_W  extended result
//  Out_Valid   out  1      Output valid
//  Out_Ready   in   1      consumer accepts Output
//  Xfer_Count  out  CNT_W  output transfers completed (feature only)
// BEHAVIOUR
//  - Reset (Reset==0 at a Clock edge): Out_Valid=0, Output=0, In_Ready=1,
//    Xfer_Count=0, FSM=EMPTY. Buffered data is discarded; a handshake in flight
//    during reset is lost. Reset takes priority over all other events.
//  - Accept: In_Valid&In_Ready. Emit: Out_Valid&Out_Ready.
//  - Extension is computed at accept time; the stored value is the final Output.
//    00: {(OUT_W-IN_W)'0, Input}
//    01: {(OUT_W-IN_W){Input[IN_W-1]}, Input}
//    10: mode-01 result << 1; the MSB is dropped and bit 0 is 0
//    11: {Input, (OUT_W-IN_W)'0}
//  - When IN_W==OUT_W, modes 00, 01 and 11 pass Input through unchanged.
//  - Latency: an accept at edge N gives Out_Valid=1 after edge N (1 cycle).
//  - FSM: EMPTY (0 words), ONE (Output reg holds a word), FULL (Output and skid
//    regs both hold words).
//    EMPTY: accept -> ONE.
//    ONE: accept&emit -> ONE, Output<=new; accept&!emit -> FULL, skid<=new;
//         emit only -> EMPTY.
//    FULL: emit -> ONE, Output<=skid. No accept is possible (In_Ready=0).
//  - In_Ready = (state!=FULL), registered from the next state.
//  - Out_Valid = (state!=EMPTY). Output is held stable while Out_Valid&!Out_Ready.
//  - Ordering is strict FIFO. No word is dropped or duplicated.
//  - Sustained In_Valid with Out_Ready high gives 1 word/cycle.
//  - Out_Ready may toggle freely. In_Valid may drop without a transfer.
//  - Illegal parameters (IN_W>OUT_W) are an elaboration error ($error).
// CONFIGURATION
//  SIGNAL_EXT_PIPE_COUNT_EN defined:
//   - Xfer_Count increments on every emit and wraps from 2^CNT_W-1 to 0.
//   - Reset clears it to 0.
//  Undefined:
//   - Xfer_Count is tied to 0 and no counter flops are built.
//   - All other behaviour is identical.
// TESTING
//  1 Reset low 2 cycles, then high -> Out_Valid=0, In_Ready=1, Output=0, Xfer_Count=0
//  2 IN_W=11,OUT_W=16, Out_Ready=1. Inputs 0, 11'b10000000000, 11'b01111111111,
//    mode 01 -> next-cycle Outputs 16'h0000, 16'hFC00, 16'h03FF
//  3 Input 11'h400 in all modes -> 00:16'h0400, 01:16'hFC00, 10:16'hF800,
//    11:16'h8000 (for 11, Input=11'h401 -> 16'h8020)
//  4 Out_Ready=0, push 3 words with In_Valid=1 -> 2 accepted, then In_Ready=0.
//    Output holds word 1. Release Out_Ready -> words 1,2 drained in order,
//    In_Ready back to 1 one cycle later.
//  5 FULL state, assert Reset mid-stream -> next cycle EMPTY, Out_Valid=0,
//    no stale word appears after reset release
//  6 COUNT_EN, CNT_W=4, 17 emits -> Xfer_Count=1 (wrap).
//    Macro undefined -> Xfer_Count stays 0.

Source files
------------

// File: rtl/signal_extension_pipe.sv
// signal_extension_pipe: widens an IN_W immediate to OUT_W (zero/sign/sign<<1/upper) behind a valid/ready pipe.
// Latency: 1 cycle from accept to Out_Valid; sustains 1 word/cycle when Out_Ready stays high.
// Backpressure: 2-entry skid (Output reg + skid reg); In_Ready is registered and drops only when both hold words.
//
// Ports:
//   Clock       rising-edge clock
//   Reset       synchronous, active-low reset
//   Input       IN_W-bit immediate to extend
//   Mode        00 zero, 01 sign, 10 sign<<1, 11 upper-load
//   In_Valid    Input/Mode valid
//   In_Ready    block accepts Input this cycle (registered)
//   Output      OUT_W-bit extended result
//   Out_Valid   Output valid
//   Out_Ready   consumer accepts Output
//   Xfer_Count  completed output transfers (counter only with SIGNAL_EXT_PIPE_COUNT_EN, else 0)
//
// Optional feature macro: SIGNAL_EXT_PIPE_COUNT_EN builds the wrapping transfer counter.

module signal_extension_pipe #(
  parameter int IN_W  = 11,
  parameter int OUT_W = 16,
  parameter int CNT_W = 16
) (
  input  logic             Clock,
  input  logic             Reset,
  input  logic [IN_W-1:0]  Input,
  input  logic [1:0]       Mode,
  input  logic             In_Valid,
  output logic             In_Ready,
  output logic [OUT_W-1:0] Output,
  output logic             Out_Valid,
  input  logic             Out_Ready,
  output logic [CNT_W-1:0] Xfer_Count
);

  if (IN_W < 1 || IN_W > OUT_W || OUT_W > 32) begin : g_bad_params
    $error("signal_extension_pipe: illegal widths IN_W=%0d OUT_W=%0d", IN_W, OUT_W);
  end

  typedef enum logic [1:0] {
    EMPTY = 2'd0,
    ONE   = 2'd1,
    FULL  = 2'd2
  } state_t;

  state_t           state;
  logic [OUT_W-1:0] out_reg;
  logic [OUT_W-1:0] skid_reg;
  logic             in_rdy_reg;
  logic             out_vld_reg;

  logic             accept;
  logic             emit;

  // Extension datapath. Built by overlaying Input onto a filled vector so the
  // IN_W==OUT_W case needs no zero-width replication.
  logic [OUT_W-1:0] zext;
  logic [OUT_W-1:0] sext;
  logic [OUT_W-1:0] upper;
  logic [OUT_W-1:0] ext_val;

  always_comb begin
    zext               = '0;
    zext[IN_W-1:0]     = Input;
    sext               = {OUT_W{Input[IN_W-1]}};
    sext[IN_W-1:0]     = Input;
    upper              = '0;
    upper[OUT_W-1 -: IN_W] = Input;
    ext_val            = zext;
    case (Mode)
      2'b00:   ext_val = zext;
      2'b01:   ext_val = sext;
      2'b10:   ext_val = sext << 1;  // MSB falls off, bit 0 becomes 0
      default: ext_val = upper;
    endcase
  end

  assign accept = In_Valid & in_rdy_reg;
  assign emit   = out_vld_reg & Out_Ready;

  // Output reg always holds the oldest word; skid reg holds the second one
  // only while a stalled consumer let the producer push one more.
  always_ff @(posedge Clock) begin
    if (!Reset) begin
      state       <= EMPTY;
      out_reg     <= '0;
      skid_reg    <= '0;
      in_rdy_reg  <= 1'b1;
      out_vld_reg <= 1'b0;
    end else begin
      case (state)
        EMPTY: begin
          if (accept) begin
            out_reg     <= ext_val;
            state       <= ONE;
            out_vld_reg <= 1'b1;
            in_rdy_reg  <= 1'b1;
          end
        end
        ONE: begin
          if (accept && emit) begin
            out_reg <= ext_val;
          end else if (accept) begin
            skid_reg   <= ext_val;
            state      <= FULL;
            in_rdy_reg <= 1'b0;
          end else if (emit) begin
            state       <= EMPTY;
            out_vld_reg <= 1'b0;
          end
        end
        FULL: begin
          // In_Ready is low here, so only the drain side can move.
          if (emit) begin
            out_reg    <= skid_reg;
            state      <= ONE;
            in_rdy_reg <= 1'b1;
          end
        end
        default: begin
          state       <= EMPTY;
          in_rdy_reg  <= 1'b1;
          out_vld_reg <= 1'b0;
        end
      endcase
    end
  end

  assign In_Ready  = in_rdy_reg;
  assign Out_Valid = out_vld_reg;
  assign Output    = out_reg;

`ifdef SIGNAL_EXT_PIPE_COUNT_EN
  logic [CNT_W-1:0] xfer_cnt;

  always_ff @(posedge Clock) begin
    if (!Reset) begin
      xfer_cnt <= '0;
    end else if (emit) begin
      xfer_cnt <= xfer_cnt + CNT_W'(1);  // wraps naturally at 2^CNT_W
    end
  end

  assign Xfer_Count = xfer_cnt;
`else
  assign Xfer_Count = '0;
`endif

endmodule

// File: tb/tb_signal_extension_pipe.sv
module tb_signal_extension_pipe;

  localparam int IW = 11;
  localparam int OW = 16;
  localparam int CW = 4;

  logic          clk;
  logic          rst_n;
  logic [IW-1:0] in_data;
  logic [1:0]    mode;
  logic          in_valid;
  logic          in_ready;
  logic [OW-1:0] out_data;
  logic          out_valid;
  logic          out_ready;
  logic [CW-1:0] xfer_count;

  int checks = 0;
  int errors = 0;

  // Reference model: an ordered list of words in flight plus a transfer tally.
  logic [OW-1:0] m_q[$];
  int            m_cnt = 0;

  signal_extension_pipe #(.IN_W(IW), .OUT_W(OW), .CNT_W(CW)) dut (
    .Clock      (clk),
    .Reset      (rst_n),
    .Input      (in_data),
    .Mode       (mode),
    .In_Valid   (in_valid),
    .In_Ready   (in_ready),
    .Output     (out_data),
    .Out_Valid  (out_valid),
    .Out_Ready  (out_ready),
    .Xfer_Count (xfer_count)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Extension from the arithmetic meaning of each mode.
  function automatic logic [OW-1:0] ref_ext(input logic [IW-1:0] d, input logic [1:0] m);
    longint v;
    longint s;
    longint r;
    v = longint'(d);
    s = d[IW-1] ? v - (longint'(1) << IW) : v;
    case (m)
      2'd0:    r = v;
      2'd1:    r = s;
      2'd2:    r = s * 2;
      default: r = v * (longint'(1) << (OW - IW));
    endcase
    return r[OW-1:0];
  endfunction

  task automatic chk(input string name, input longint act, input longint exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  // One clock edge: update the model from pre-edge inputs, then compare
  // every output 1 time unit after the edge.
  task automatic cycle();
    bit            acc;
    bit            emt;
    logic [OW-1:0] w;
    acc = in_valid && (m_q.size() < 2);
    emt = (m_q.size() != 0) && out_ready;
    w   = ref_ext(in_data, mode);
    @(posedge clk);
    if (!rst_n) begin
      m_q.delete();
      m_cnt = 0;
    end else begin
      if (emt) begin
        void'(m_q.pop_front());
`ifdef SIGNAL_EXT_PIPE_COUNT_EN
        m_cnt = (m_cnt + 1) % (1 << CW);
`endif
      end
      if (acc) m_q.push_back(w);
    end
    #1;
    chk("in_ready", longint'(in_ready), longint'(m_q.size() < 2));
    chk("out_valid", longint'(out_valid), longint'(m_q.size() != 0));
    if (m_q.size() != 0) chk("output", longint'(out_data), longint'(m_q[0]));
    chk("xfer_count", longint'(xfer_count), longint'(m_cnt));
  endtask

  typedef struct {
    logic [IW-1:0] din;
    logic [1:0]    md;
    logic [OW-1:0] exp;
  } vec_t;

  vec_t tbl[10];

  initial begin
    tbl[0] = '{11'h000, 2'b01, 16'h0000};
    tbl[1] = '{11'h400, 2'b01, 16'hFC00};
    tbl[2] = '{11'h3FF, 2'b01, 16'h03FF};
    tbl[3] = '{11'h400, 2'b00, 16'h0400};
    tbl[4] = '{11'h400, 2'b10, 16'hF800};
    tbl[5] = '{11'h400, 2'b11, 16'h8000};
    tbl[6] = '{11'h401, 2'b11, 16'h8020};
    tbl[7] = '{11'h7FF, 2'b10, 16'hFFFE};
    tbl[8] = '{11'h3FF, 2'b10, 16'h07FE};
    tbl[9] = '{11'h7FF, 2'b00, 16'h07FF};

    rst_n = 1'b0; in_data = '0; mode = 2'b00; in_valid = 1'b0; out_ready = 1'b0;

    // Reset held for two edges.
    cycle();
    cycle();
    chk("reset_output", longint'(out_data), 0);
    chk("reset_in_ready", longint'(in_ready), 1);
    chk("reset_out_valid", longint'(out_valid), 0);
    chk("reset_count", longint'(xfer_count), 0);
    rst_n = 1'b1;
    cycle();

    // Table vectors streamed back to back; each result appears one edge later.
    out_ready = 1'b1;
    for (int i = 0; i < 10; i++) begin
      in_valid = 1'b1; in_data = tbl[i].din; mode = tbl[i].md;
      cycle();
      chk($sformatf("tbl%0d_output", i), longint'(out_data), longint'(tbl[i].exp));
      chk($sformatf("tbl%0d_valid", i), longint'(out_valid), 1);
    end
    in_valid = 1'b0;
    cycle();

    // Stalled consumer: three pushes, only two accepted.
    out_ready = 1'b0; in_valid = 1'b1; mode = 2'b01;
    in_data = 11'h123; cycle();
    in_data = 11'h456; cycle();
    chk("stall_in_ready_low", longint'(in_ready), 0);
    in_data = 11'h789; cycle();
    chk("stall_hold_word1", longint'(out_data), longint'(16'h0123));
    in_valid = 1'b0; out_ready = 1'b1;
    cycle();
    chk("drain_word2", longint'(out_data), longint'(16'hFC56));
    chk("drain_in_ready_back", longint'(in_ready), 1);
    cycle();
    chk("drain_empty", longint'(out_valid), 0);

    // Reset while FULL: everything buffered is discarded.
    out_ready = 1'b0; in_valid = 1'b1; in_data = 11'h055; mode = 2'b00;
    cycle(); cycle();
    chk("full_before_reset", longint'(in_ready), 0);
    rst_n = 1'b0; in_valid = 1'b0;
    cycle();
    chk("rst_mid_out_valid", longint'(out_valid), 0);
    chk("rst_mid_in_ready", longint'(in_ready), 1);
    rst_n = 1'b1; out_ready = 1'b1;
    for (int i = 0; i < 3; i++) begin
      cycle();
      chk("no_stale_word", longint'(out_valid), 0);
    end

    // 17 emits after reset: a 4-bit counter wraps to 1 when built.
    in_valid = 1'b1;
    for (int i = 0; i < 17; i++) begin
      in_data = 11'($urandom); mode = 2'($urandom);
      cycle();
    end
    in_valid = 1'b0;
    cycle();
`ifdef SIGNAL_EXT_PIPE_COUNT_EN
    chk("count_wrap", longint'(xfer_count), 1);
`else
    chk("count_tied_zero", longint'(xfer_count), 0);
`endif

    // Random traffic against the model.
    for (int i = 0; i < 3000; i++) begin
      in_valid  = ($urandom_range(0, 3) != 0);
      out_ready = ($urandom_range(0, 2) != 0);
      in_data   = 11'($urandom);
      mode      = 2'($urandom);
      cycle();
    end

    // Drain whatever is left.
    in_valid = 1'b0; out_ready = 1'b1;
    cycle(); cycle(); cycle();
    chk("final_empty", longint'(out_valid), 0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
